// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, bus ACK levels and bit-counter sizing.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = '1;

    // Address phase frame is {addr[6:0], rw}.
    function automatic logic addr_match(input logic [7:0] frame, input logic [6:0] tgt);
        return frame[7:1] == tgt;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings raw SCL/SDA into the clk domain and derives edge and START/STOP events.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_pipe;
    logic [1:0] sda_pipe;
    logic       scl_s;
    logic       scl_d;
    logic       sda_d;

    // Reset to the idle-bus level so no spurious edge appears right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_pipe <= 2'b11;
            sda_pipe <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[0], scl_i};
            sda_pipe <= {sda_pipe[0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_pipe[1];
    assign sda_s     = sda_pipe[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a register pointer into an external 8-bit register file, auto-incrementing
// on every data byte. SDA is open-drain: sda_oe=1 pulls the line low.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR  = 7'h50,
    parameter logic [7:0] PTR_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_t                state, state_nxt;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic                  byte_done, byte_done_nxt;
    logic                  rw, rw_nxt;
    logic                  acked, acked_nxt;
    logic [7:0]            shifter, shifter_nxt;
    logic [7:0]            reg_addr_nxt, reg_wdata_nxt;
    logic                  sda_oe_nxt, wr_en_nxt, busy_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            acked     <= 1'b0;
            shifter   <= 8'h00;
            reg_addr  <= PTR_RESET;
            reg_wdata <= 8'h00;
            sda_oe    <= 1'b0;
            reg_wr_en <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_done <= byte_done_nxt;
            rw        <= rw_nxt;
            acked     <= acked_nxt;
            shifter   <= shifter_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wdata <= reg_wdata_nxt;
            sda_oe    <= sda_oe_nxt;
            reg_wr_en <= wr_en_nxt;
            busy      <= busy_nxt;
        end
    end

    // byte_done marks the 8th SCL rise; the byte is acted on at the following SCL fall,
    // which keeps every sda_oe change inside the SCL low phase.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        byte_done_nxt = byte_done;
        rw_nxt        = rw;
        acked_nxt     = acked;
        shifter_nxt   = shifter;
        reg_addr_nxt  = reg_addr;
        reg_wdata_nxt = reg_wdata;
        sda_oe_nxt    = sda_oe;
        wr_en_nxt     = 1'b0;
        busy_nxt      = busy;

        if (reg_wr_en) begin
            reg_addr_nxt = reg_addr + 8'd1;
        end

        if (start_det) begin
            state_nxt     = ST_ADDR;
            bit_cnt_nxt   = '0;
            byte_done_nxt = 1'b0;
            acked_nxt     = 1'b0;
            sda_oe_nxt    = 1'b0;
        end else if (stop_det) begin
            state_nxt     = ST_IDLE;
            bit_cnt_nxt   = '0;
            byte_done_nxt = 1'b0;
            acked_nxt     = 1'b0;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && !byte_done) begin
                        shifter_nxt   = {shifter[6:0], sda_s};
                        bit_cnt_nxt   = bit_cnt + 1'b1;
                        byte_done_nxt = (bit_cnt == LAST_BIT);
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        bit_cnt_nxt   = '0;
                        sda_oe_nxt    = ~I2C_ACK;
                        case (state)
                            ST_ADDR: begin
                                if (addr_match(shifter, TGT_ADDR)) begin
                                    busy_nxt  = 1'b1;
                                    rw_nxt    = shifter[0];
                                    state_nxt = ST_ADDR_ACK;
                                end else begin
                                    sda_oe_nxt = 1'b0;
                                    busy_nxt   = 1'b0;
                                    state_nxt  = ST_WAIT_STOP;
                                end
                            end
                            ST_PTR: begin
                                reg_addr_nxt = shifter;
                                state_nxt    = ST_PTR_ACK;
                            end
                            default: begin
                                reg_wdata_nxt = shifter;
                                wr_en_nxt     = 1'b1;
                                state_nxt     = ST_WDATA_ACK;
                            end
                        endcase
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nxt   = '0;
                        byte_done_nxt = 1'b0;
                        if (rw) begin
                            shifter_nxt = reg_rdata;
                            sda_oe_nxt  = ~reg_rdata[7];
                            state_nxt   = ST_RDATA;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = ST_PTR;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && !byte_done) begin
                        bit_cnt_nxt   = bit_cnt + 1'b1;
                        byte_done_nxt = (bit_cnt == LAST_BIT);
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            sda_oe_nxt    = 1'b0;
                            byte_done_nxt = 1'b0;
                            bit_cnt_nxt   = '0;
                            acked_nxt     = 1'b0;
                            state_nxt     = ST_RDATA_ACK;
                        end else if (bit_cnt != '0) begin
                            shifter_nxt = {shifter[6:0], 1'b0};
                            sda_oe_nxt  = ~shifter[6];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    // The pointer advances on the ACK clock either way, so a NACKed read
                    // still leaves the pointer past the last byte sent.
                    if (scl_rise && !acked) begin
                        reg_addr_nxt = reg_addr + 8'd1;
                        if (sda_s == I2C_NACK) begin
                            busy_nxt  = 1'b0;
                            state_nxt = ST_WAIT_STOP;
                        end else begin
                            acked_nxt = 1'b1;
                        end
                    end else if (scl_fall && acked) begin
                        acked_nxt   = 1'b0;
                        bit_cnt_nxt = '0;
                        shifter_nxt = reg_rdata;
                        sda_oe_nxt  = ~reg_rdata[7];
                        state_nxt   = ST_RDATA;
                    end
                end
                default: begin
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, behavioural register file, and a pointer/data reference model.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, reg_wr_en, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       sda_line;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target #(.TGT_ADDR(7'h50), .PTR_RESET(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_a = 8'h00, pre_d = 8'h00;

    assign reg_rdata = mem[reg_addr];

    always @(posedge clk) begin
        if (reg_wr_en === 1'b1) mem[reg_addr] <= reg_wdata;
        else if (pre_we) mem[pre_a] <= pre_d;
    end

    // Protocol monitors: strobe log, double-strobe and SDA-while-SCL-high detectors.
    logic [15:0] wr_log [1024];
    int          wr_count = 0;
    int          wr_double = 0;
    int          oe_in_high = 0;
    int          oe_cnt = 0;
    logic        prev_wr = 1'b0, prev_oe = 1'b0;
    logic        s1 = 1'b1, s2 = 1'b1, s2_prev = 1'b1;

    always @(posedge clk) begin
        s1 <= scl_m;
        s2 <= s1;
        s2_prev <= s2;
    end

    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) begin
            wr_log[wr_count[9:0]] = {reg_addr, reg_wdata};
            wr_count++;
            if (prev_wr === 1'b1) wr_double++;
        end
        if (!rst && sda_oe !== prev_oe && s2 && s2_prev) oe_in_high++;
        if (sda_oe === 1'b1) oe_cnt++;
        prev_wr = reg_wr_en;
        prev_oe = sda_oe;
    end

    int         checks = 0;
    int         failures = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] exp_ptr = 8'h00;

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
        qwait();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b; qwait();
        scl_m = 1'b1; qwait();
        s = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_in, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(ack_in, s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_sda_oe actual=%b required=0", sda_oe); end
        checks++; if (reg_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en actual=%b required=0", reg_wr_en); end
        checks++; if (reg_wdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_wdata actual=%h required=00", reg_wdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
        checks++; if (reg_addr !== 8'h00) begin failures++; $display("[TB] FAIL reset_reg_addr actual=%h required=00", reg_addr); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        exp_ptr = 8'h00;
    endtask

    task automatic test_write_basic();
        int base = wr_count;
        logic [3:0] acks;
        logic a;
        bus_start();
        send_byte(8'hA0, a); acks[0] = a;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL write_busy actual=%b required=1", busy); end
        send_byte(8'h10, a); acks[1] = a;
        send_byte(8'h5A, a); acks[2] = a;
        send_byte(8'hC3, a); acks[3] = a;
        bus_stop();
        for (int i = 0; i < 4; i++) begin
            checks++; if (acks[i] !== 1'b0) begin failures++; $display("[TB] FAIL write_ack%0d actual=%b required=0", i, acks[i]); end
        end
        checks++; if (wr_count - base !== 2) begin failures++; $display("[TB] FAIL write_strobe_count actual=%0d required=2", wr_count - base); end
        checks++; if (wr_log[base[9:0]] !== 16'h105A) begin failures++; $display("[TB] FAIL write_strobe0 actual=%h required=105a", wr_log[base[9:0]]); end
        checks++; if (wr_log[(base + 1) % 1024] !== 16'h11C3) begin failures++; $display("[TB] FAIL write_strobe1 actual=%h required=11c3", wr_log[(base + 1) % 1024]); end
        checks++; if (reg_addr !== 8'h12) begin failures++; $display("[TB] FAIL write_final_ptr actual=%h required=12", reg_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL write_busy_after_stop actual=%b required=0", busy); end
        ref_mem[8'h10] = 8'h5A; ref_mem[8'h11] = 8'hC3; exp_ptr = 8'h12;
    endtask

    task automatic test_read_rs();
        int base;
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        poke(8'h20, 8'h96);
        poke(8'h21, 8'h3C);
        base = wr_count;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h20, a1);
        bus_start();
        send_byte(8'hA1, a2);
        recv_byte(1'b0, d0);
        recv_byte(1'b1, d1);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL read_busy_after_nack actual=%b required=0", busy); end
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL read_released actual=%b required=0", sda_oe); end
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("[TB] FAIL read_acks actual=%b required=000", {a0, a1, a2}); end
        checks++; if (d0 !== 8'h96) begin failures++; $display("[TB] FAIL read_byte0 actual=%h required=96", d0); end
        checks++; if (d1 !== 8'h3C) begin failures++; $display("[TB] FAIL read_byte1 actual=%h required=3c", d1); end
        checks++; if (wr_count !== base) begin failures++; $display("[TB] FAIL read_no_strobe actual=%0d required=%0d", wr_count, base); end
        checks++; if (reg_addr !== 8'h22) begin failures++; $display("[TB] FAIL read_final_ptr actual=%h required=22", reg_addr); end
        exp_ptr = 8'h22;
    endtask

    task automatic test_mismatch();
        int base = wr_count;
        int oe_base = oe_cnt;
        logic a0, a1;
        bus_start();
        send_byte(8'hA2, a0);
        send_byte(8'h55, a1);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_busy actual=%b required=0", busy); end
        bus_stop();
        checks++; if ({a0, a1} !== 2'b11) begin failures++; $display("[TB] FAIL mismatch_nack actual=%b required=11", {a0, a1}); end
        checks++; if (oe_cnt !== oe_base) begin failures++; $display("[TB] FAIL mismatch_sda_driven actual=%0d required=%0d", oe_cnt, oe_base); end
        checks++; if (wr_count !== base) begin failures++; $display("[TB] FAIL mismatch_strobes actual=%0d required=%0d", wr_count, base); end
        checks++; if (reg_addr !== exp_ptr) begin failures++; $display("[TB] FAIL mismatch_ptr actual=%h required=%h", reg_addr, exp_ptr); end
    endtask

    task automatic test_wrap();
        int base = wr_count;
        logic a0, a1, a2, a3;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        bus_stop();
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("[TB] FAIL wrap_acks actual=%b required=0000", {a0, a1, a2, a3}); end
        checks++; if (wr_count - base !== 2) begin failures++; $display("[TB] FAIL wrap_strobe_count actual=%0d required=2", wr_count - base); end
        checks++; if (wr_log[base[9:0]] !== 16'hFF11) begin failures++; $display("[TB] FAIL wrap_strobe0 actual=%h required=ff11", wr_log[base[9:0]]); end
        checks++; if (wr_log[(base + 1) % 1024] !== 16'h0022) begin failures++; $display("[TB] FAIL wrap_strobe1 actual=%h required=0022", wr_log[(base + 1) % 1024]); end
        checks++; if (reg_addr !== 8'h01) begin failures++; $display("[TB] FAIL wrap_final_ptr actual=%h required=01", reg_addr); end
        ref_mem[8'hFF] = 8'h11; ref_mem[8'h00] = 8'h22; exp_ptr = 8'h01;
    endtask

    task automatic test_abort_stop();
        int base = wr_count;
        logic a, s;
        bus_start();
        send_byte(8'hA0, a);
        send_byte(8'h30, a);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), s);
        bus_stop();
        checks++; if (wr_count !== base) begin failures++; $display("[TB] FAIL abort_no_strobe actual=%0d required=%0d", wr_count, base); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy actual=%b required=0", busy); end
        checks++; if (reg_addr !== 8'h30) begin failures++; $display("[TB] FAIL abort_ptr actual=%h required=30", reg_addr); end
        exp_ptr = 8'h30;
    endtask

    task automatic test_random_write();
        for (int t = 0; t < 3; t++) begin
            int base = wr_count;
            int n = $urandom_range(1, 4);
            logic [7:0] ptr = 8'($urandom_range(0, 255));
            logic [7:0] data [4];
            logic [4:0] acks = '0;
            logic a;
            bus_start();
            send_byte(8'hA0, a); acks[0] = a;
            send_byte(ptr, a); acks[1] = a;
            for (int i = 0; i < n; i++) begin
                data[i] = 8'($urandom_range(0, 255));
                send_byte(data[i], a); acks[i + 2] = a;
            end
            bus_stop();
            checks++; if (acks !== 5'b0) begin failures++; $display("[TB] FAIL rwrite%0d_acks actual=%b required=00000", t, acks); end
            checks++; if (wr_count - base !== n) begin failures++; $display("[TB] FAIL rwrite%0d_count actual=%0d required=%0d", t, wr_count - base, n); end
            for (int i = 0; i < n; i++) begin
                logic [7:0] ea = ptr + 8'(i);
                checks++;
                if (wr_log[(base + i) % 1024] !== {ea, data[i]}) begin
                    failures++;
                    $display("[TB] FAIL rwrite%0d_strobe%0d actual=%h required=%h", t, i, wr_log[(base + i) % 1024], {ea, data[i]});
                end
                ref_mem[ea] = data[i];
            end
            exp_ptr = ptr + 8'(n);
            checks++; if (reg_addr !== exp_ptr) begin failures++; $display("[TB] FAIL rwrite%0d_ptr actual=%h required=%h", t, reg_addr, exp_ptr); end
        end
    endtask

    task automatic test_back_to_back_read();
        for (int t = 0; t < 2; t++) begin
            int n = $urandom_range(1, 3);
            logic [7:0] ptr = 8'($urandom_range(0, 255));
            logic [7:0] d;
            logic a0, a1, a2;
            for (int i = 0; i < n + 2; i++) poke(ptr + 8'(i), 8'($urandom_range(0, 255)));
            bus_start();
            send_byte(8'hA0, a0);
            send_byte(ptr, a1);
            bus_start();
            send_byte(8'hA1, a2);
            checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("[TB] FAIL rread%0d_acks actual=%b required=000", t, {a0, a1, a2}); end
            exp_ptr = ptr;
            for (int i = 0; i < n; i++) begin
                recv_byte((i == n - 1), d);
                checks++; if (d !== ref_mem[exp_ptr]) begin failures++; $display("[TB] FAIL rread%0d_byte%0d actual=%h required=%h", t, i, d, ref_mem[exp_ptr]); end
                exp_ptr = exp_ptr + 8'd1;
            end
            bus_stop();
            // Second transaction omits the pointer byte and must continue where the first stopped.
            bus_start();
            send_byte(8'hA1, a0);
            for (int i = 0; i < 2; i++) begin
                recv_byte((i == 1), d);
                checks++; if (d !== ref_mem[exp_ptr]) begin failures++; $display("[TB] FAIL rcont%0d_byte%0d actual=%h required=%h", t, i, d, ref_mem[exp_ptr]); end
                exp_ptr = exp_ptr + 8'd1;
            end
            bus_stop();
            checks++; if (reg_addr !== exp_ptr) begin failures++; $display("[TB] FAIL rcont%0d_ptr actual=%h required=%h", t, reg_addr, exp_ptr); end
        end
    endtask

    task automatic test_reset_midread();
        logic a, s;
        logic [7:0] v = 8'($urandom_range(0, 255));
        logic [7:0] d;
        poke(8'h40, 8'h00);
        bus_start();
        send_byte(8'hA0, a);
        send_byte(8'h40, a);
        bus_start();
        send_byte(8'hA1, a);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
        sda_m = 1'b1;
        qwait();
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("[TB] FAIL midread_driving actual=%b required=1", sda_oe); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL midread_rst_sda_oe actual=%b required=0", sda_oe); end
        checks++; if (reg_addr !== 8'h00) begin failures++; $display("[TB] FAIL midread_rst_ptr actual=%h required=00", reg_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midread_rst_busy actual=%b required=0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus_stop();
        exp_ptr = 8'h00;
        poke(8'h00, v);
        bus_start();
        send_byte(8'hA1, a);
        recv_byte(1'b1, d);
        bus_stop();
        checks++; if (d !== v) begin failures++; $display("[TB] FAIL postrst_read actual=%h required=%h", d, v); end
        checks++; if (reg_addr !== 8'h01) begin failures++; $display("[TB] FAIL postrst_ptr actual=%h required=01", reg_addr); end
    endtask

    task automatic test_invariants();
        checks++; if (wr_double !== 0) begin failures++; $display("[TB] FAIL wr_en_back_to_back actual=%0d required=0", wr_double); end
        checks++; if (oe_in_high !== 0) begin failures++; $display("[TB] FAIL sda_oe_change_scl_high actual=%0d required=0", oe_in_high); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_rs();
        test_mismatch();
        test_wrap();
        test_abort_stop();
        test_random_write();
        test_back_to_back_read();
        test_reset_midread();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
